// File: rtl/pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the program-counter sequencing unit.
//   pc_sel_t         : next-PC source select encodings (6 and 7 are reserved
//                      and behave as sequential fetch).
//   PC_INC           : byte distance between consecutive instructions.
//   TRAP_VEC_DEFAULT : default redirect address for misaligned targets, used
//                      only when PC_SEQ_MISALIGN_TRAP_EN is defined.
// -----------------------------------------------------------------------------
package pc_seq_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_JMP  = 3'd1,
    SEL_BR   = 3'd2,
    SEL_JR   = 3'd3,
    SEL_CALL = 3'd4,
    SEL_RET  = 3'd5
  } pc_sel_t;

  localparam int PC_INC = 4;

  localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0080;

endpackage

// File: rtl/pc_ras.sv
// -----------------------------------------------------------------------------
// pc_ras
// Return-address stack organised as a circular buffer. tp_q points at the next
// free slot, so the top of stack is entry[tp_q-1]. When full, a push lands on
// the oldest entry (which is exactly where tp_q points) and sets the sticky
// overflow flag; the occupancy count saturates at DEPTH.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-high reset; clears entries, pointer, count
//   push   in   write wdata at tp and advance tp
//   pop    in   retreat tp (caller guarantees the stack is not empty)
//   wdata  in   value to push
//   top    out  entry[tp-1]
//   empty  out  count == 0 (registered)
//   full   out  count == DEPTH (registered)
//   ovf    out  sticky: a push overwrote a live entry
// -----------------------------------------------------------------------------
module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full,
  output logic            ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] entry_q [DEPTH];
  logic [PW-1:0]   tp_q, tp_d;
  logic [PW-1:0]   tp_m1;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;

  assign tp_m1 = tp_q - PW'(1);
  assign top   = entry_q[tp_m1];
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign ovf   = ovf_q;

  // One register per slot so every entry can be cleared on reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        entry_q[gi] <= '0;
      end else if (push && (tp_q == PW'(gi))) begin
        entry_q[gi] <= wdata;
      end
    end
  end

  always_comb begin
    tp_d    = tp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) begin
      tp_d = tp_q + PW'(1);
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end else if (pop) begin
      tp_d    = tp_m1;
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      tp_q    <= tp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// -----------------------------------------------------------------------------
// pc_seq_unit
// Owns the architectural PC and chooses the next PC each cycle from sequential,
// absolute jump, PC-relative branch, register-indirect, call and return
// sources. Calls push pc+4 onto a return-address stack; returns pop it, or
// fall back to reg_target (and set ras_unf) when the stack is empty.
// Priority per rising edge: flush > stall > normal update. Target appears on
// pc one cycle after sel is sampled.
//
// Optional feature (macro PC_SEQ_MISALIGN_TRAP_EN): a normal update whose
// target is not word aligned loads TRAP_VEC instead, and the misalign output
// is high for the one cycle in which pc holds that trap vector. The stack
// side effect of the offending CALL/RET still happens.
//
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   stall              hold pc, stack and flags
//   flush, flush_pc    redirect; overrides stall and sel, stack untouched
//   sel                next-PC source (pc_sel_t encoding)
//   imm_j              absolute jump immediate (replaces low IMM_J_W bits)
//   imm_b, ext_op      branch byte offset; ext_op=1 sign-extends
//   reg_target         JR target, and RET fallback when the stack is empty
//   pc, pc_plus4       registered PC and its sequential successor
//   ras_empty/full     registered stack occupancy status
//   ras_ovf/unf        sticky overflow / underflow flags
//   misalign           (feature only) trap indication
// -----------------------------------------------------------------------------
module pc_seq_unit
  import pc_seq_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              IMM_J_W   = 26,
  parameter int              IMM_B_W   = 16,
  parameter int              RAS_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC  = '0
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  ,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(TRAP_VEC_DEFAULT)
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [XLEN-1:0]    flush_pc,
  input  logic [2:0]         sel,
  input  logic [IMM_J_W-1:0] imm_j,
  input  logic [IMM_B_W-1:0] imm_b,
  input  logic               ext_op,
  input  logic [XLEN-1:0]    reg_target,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pc_plus4,
  output logic               ras_empty,
  output logic               ras_full,
  output logic               ras_ovf,
  output logic               ras_unf
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  ,
  output logic               misalign
`endif
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] jmp_target;
  logic [XLEN-1:0] imm_b_ext;
  logic [XLEN-1:0] ras_top;
  logic            advance;
  logic            ras_push, ras_pop;
  logic            ret_unf;
  logic            unf_q, unf_d;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + XLEN'(PC_INC);
  assign ras_unf  = unf_q;

  // Only an unflushed, unstalled cycle may touch the stack or the flags.
  assign advance = !flush && !stall;

  assign jmp_target = {pc_q[XLEN-1:IMM_J_W], imm_j};
  assign imm_b_ext  = ext_op ? {{(XLEN-IMM_B_W){imm_b[IMM_B_W-1]}}, imm_b}
                             : {{(XLEN-IMM_B_W){1'b0}}, imm_b};

  always_comb begin
    target   = pc_plus4;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ret_unf  = 1'b0;
    case (sel)
      SEL_JMP: target = jmp_target;
      SEL_BR:  target = pc_plus4 + imm_b_ext;
      SEL_JR:  target = reg_target;
      SEL_CALL: begin
        target   = jmp_target;
        ras_push = advance;
      end
      SEL_RET: begin
        if (!ras_empty) begin
          target  = ras_top;
          ras_pop = advance;
        end else begin
          target  = reg_target;
          ret_unf = advance;
        end
      end
      default: target = pc_plus4;  // SEQ and reserved codes
    endcase
  end

  assign unf_d = unf_q | ret_unf;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  logic mis_q, mis_d;

  assign misalign = mis_q;

  always_comb begin
    mis_d = 1'b0;
    if (flush) begin
      pc_d = flush_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (target[1:0] != 2'b00) begin
      pc_d  = TRAP_VEC;
      mis_d = 1'b1;
    end else begin
      pc_d = target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end
`else
  always_comb begin
    if (flush) begin
      pc_d = flush_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = target;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      unf_q <= unf_d;
    end
  end

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .wdata (pc_plus4),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full),
    .ovf   (ras_ovf)
  );

endmodule

// File: tb/tb_pc_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_seq_unit
// Directed scenarios plus a randomized run of pc_seq_unit against a queue-based
// reference model of the PC and return-address stack.
// -----------------------------------------------------------------------------
module tb_pc_seq_unit;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 8;
  localparam logic [31:0] RST_PC   = 32'h0;
  localparam logic [31:0] TRAP     = 32'h0000_0080;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic [2:0]  sel;
  logic [25:0] imm_j;
  logic [15:0] imm_b;
  logic        ext_op;
  logic [31:0] reg_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_unf;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf;
  logic        m_unf;
  logic        m_mis;

  pc_seq_unit dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .sel        (sel),
    .imm_j      (imm_j),
    .imm_b      (imm_b),
    .ext_op     (ext_op),
    .reg_target (reg_target),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .ras_ovf    (ras_ovf),
    .ras_unf    (ras_unf)
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    ,
    .misalign   (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_pc  = RST_PC;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_mis = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    logic [31:0] off;
    m_mis = 1'b0;
    if (flush) begin
      m_pc = flush_pc;
    end else if (!stall) begin
      off = ext_op ? 32'($signed(imm_b)) : 32'(imm_b);
      case (sel)
        3'd1: tgt = (m_pc & 32'hFC00_0000) | 32'(imm_j);
        3'd2: tgt = m_pc + 32'd4 + off;
        3'd3: tgt = reg_target;
        3'd4: begin
          tgt = (m_pc & 32'hFC00_0000) | 32'(imm_j);
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
        end
        3'd5: begin
          if (m_ras.size() > 0) begin
            tgt = m_ras.pop_back();
          end else begin
            tgt   = reg_target;
            m_unf = 1'b1;
          end
        end
        default: tgt = m_pc + 32'd4;
      endcase
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      if (tgt[1:0] != 2'b00) begin
        tgt   = TRAP;
        m_mis = 1'b1;
      end
`endif
      m_pc = tgt;
    end
  endtask

  task automatic idle();
    stall      = 1'b0;
    flush      = 1'b0;
    flush_pc   = '0;
    sel        = 3'd0;
    imm_j      = '0;
    imm_b      = '0;
    ext_op     = 1'b0;
    reg_target = '0;
  endtask

  // Advance one clock with the currently driven inputs; outputs are sampled
  // 1 ns after the rising edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    $display("cycle sel=%0d stall=%b flush=%b pc=%08h empty=%b full=%b ovf=%b unf=%b",
             sel, stall, flush, pc, ras_empty, ras_full, ras_ovf, ras_unf);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    idle();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc !== RST_PC) begin errors++; $display("FAIL reset_pc got=%08h exp=%08h", pc, RST_PC); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", ras_empty); end
    checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", ras_full); end
    checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", ras_ovf, ras_unf); end
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      sel = 3'd0;
      tick();
      exp_pc = 32'(i * 4);
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL seq_pc got=%08h exp=%08h", pc, exp_pc); end
      checks++; if (pc_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_pc_plus4 got=%08h exp=%08h", pc_plus4, exp_pc + 32'd4); end
    end
    // Asynchronous reset away from the clock edge
    #2;
    reset = 1'b1;
    #1;
    checks++; if (pc !== RST_PC) begin errors++; $display("FAIL async_reset_pc got=%08h exp=%08h", pc, RST_PC); end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_branch();
    idle();
    flush = 1'b1; flush_pc = 32'h100; tick();
    idle();
    sel = 3'd2; imm_b = 16'hFFF0; ext_op = 1'b1; tick();
    checks++; if (pc !== 32'h0000_00F4) begin errors++; $display("FAIL br_sext got=%08h exp=000000f4", pc); end
    idle();
    flush = 1'b1; flush_pc = 32'h100; tick();
    idle();
    sel = 3'd2; imm_b = 16'hFFF0; ext_op = 1'b0; tick();
    checks++; if (pc !== 32'h0001_00F4) begin errors++; $display("FAIL br_zext got=%08h exp=000100f4", pc); end
  endtask

  task automatic test_call_ret();
    idle();
    flush = 1'b1; flush_pc = 32'h4000_0010; tick();
    idle();
    sel = 3'd4; imm_j = 26'h0000200; tick();
    checks++; if (pc !== 32'h4000_0200) begin errors++; $display("FAIL call_pc got=%08h exp=40000200", pc); end
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL call_empty got=%b exp=0", ras_empty); end
    idle();
    sel = 3'd5; reg_target = 32'hDEAD_0000; tick();
    checks++; if (pc !== 32'h4000_0014) begin errors++; $display("FAIL ret_pc got=%08h exp=40000014", pc); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty got=%b exp=1", ras_empty); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      idle();
      flush = 1'b1; flush_pc = 32'h1000 + 32'(i * 32'h100); tick();
      idle();
      sel = 3'd4; imm_j = 26'h40; tick();
    end
    checks++; if (ras_full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", ras_full); end
    checks++; if (ras_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", ras_ovf); end
    for (int k = 0; k < 9; k++) begin
      idle();
      sel = 3'd5; reg_target = 32'hDEAD_BEE0; tick();
      exp_pc = (k < 8) ? 32'h1000 + 32'((8 - k) * 32'h100) + 32'd4 : 32'hDEAD_BEE0;
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL ret_order_%0d got=%08h exp=%08h", k, pc, exp_pc); end
      if (k == 7) begin
        checks++; if (ras_empty !== 1'b1 || ras_unf !== 1'b0) begin errors++; $display("FAIL drained got=empty%b unf%b exp=empty1 unf0", ras_empty, ras_unf); end
      end
    end
    checks++; if (ras_unf !== 1'b1) begin errors++; $display("FAIL unf_flag got=%b exp=1", ras_unf); end
  endtask

  task automatic test_stall_flush();
    do_reset();
    idle();
    flush = 1'b1; flush_pc = 32'h500; tick();
    idle();
    sel = 3'd4; imm_j = 26'h40; tick();
    idle();
    stall = 1'b1; flush = 1'b1; flush_pc = 32'h200; sel = 3'd4; imm_j = 26'h80; tick();
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL flush_pc got=%08h exp=00000200", pc); end
    idle();
    stall = 1'b1; sel = 3'd3; reg_target = 32'h300; tick();
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL stall_hold got=%08h exp=00000200", pc); end
    idle();
    sel = 3'd5; reg_target = 32'h900; tick();
    checks++; if (pc !== 32'h504) begin errors++; $display("FAIL flush_ras_top got=%08h exp=00000504", pc); end
    checks++; if (ras_empty !== 1'b1 || ras_unf !== 1'b0) begin errors++; $display("FAIL flush_ras_count got=empty%b unf%b exp=empty1 unf0", ras_empty, ras_unf); end
  endtask

  task automatic test_misalign();
    idle();
    flush = 1'b1; flush_pc = 32'h100; tick();
    idle();
    sel = 3'd3; reg_target = 32'h102; tick();
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    checks++; if (pc !== TRAP) begin errors++; $display("FAIL trap_pc got=%08h exp=%08h", pc, TRAP); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL trap_pulse got=%b exp=1", misalign); end
    idle();
    tick();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL trap_pulse_end got=%b exp=0", misalign); end
    checks++; if (pc !== TRAP + 32'd4) begin errors++; $display("FAIL trap_seq got=%08h exp=%08h", pc, TRAP + 32'd4); end
`else
    checks++; if (pc !== 32'h102) begin errors++; $display("FAIL misaligned_load got=%08h exp=00000102", pc); end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      idle();
      stall      = ($urandom_range(0, 4) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      flush_pc   = $urandom & 32'hFFFF_FFFC;
      sel        = 3'($urandom_range(0, 7));
      imm_j      = 26'($urandom);
      imm_b      = 16'($urandom);
      ext_op     = 1'($urandom);
      reg_target = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      tick();
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc_%0d got=%08h exp=%08h", i, pc, m_pc); end
      checks++; if (pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pc_plus4_%0d got=%08h exp=%08h", i, pc_plus4, m_pc + 32'd4); end
      checks++; if (ras_empty !== (m_ras.size() == 0)) begin errors++; $display("FAIL rnd_empty_%0d got=%b exp=%b", i, ras_empty, m_ras.size() == 0); end
      checks++; if (ras_full !== (m_ras.size() == DEPTH)) begin errors++; $display("FAIL rnd_full_%0d got=%b exp=%b", i, ras_full, m_ras.size() == DEPTH); end
      checks++; if (ras_ovf !== m_ovf || ras_unf !== m_unf) begin errors++; $display("FAIL rnd_flags_%0d got=%b%b exp=%b%b", i, ras_ovf, ras_unf, m_ovf, m_unf); end
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      checks++; if (misalign !== m_mis) begin errors++; $display("FAIL rnd_misalign_%0d got=%b exp=%b", i, misalign, m_mis); end
`endif
      if (i == 200) begin
        #2;
        reset = 1'b1;
        #1;
        checks++; if (pc !== RST_PC || ras_empty !== 1'b1) begin errors++; $display("FAIL rnd_async_reset got=%08h empty%b exp=%08h empty1", pc, ras_empty, RST_PC); end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    test_reset();
    test_branch();
    test_call_ret();
    test_overflow();
    test_stall_flush();
    test_misalign();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
- Next-generation program-counter unit: owns the architectural PC register and selects the next PC each cycle.
- Next-PC sources: sequential, absolute jump, PC-relative branch, register-indirect jump, call and return.
- A return-address stack (RAS) predicts return targets.
- Sits at the head of the fetch stage; the instruction-memory address comes straight from pc.

Parameters:
- XLEN, 32, PC/data width in bits.
- IMM_J_W, 26, width of the absolute-jump immediate.
- IMM_B_W, 16, width of the branch immediate.
- RAS_DEPTH, 8, return-stack entries (power of 2, at least 2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- stall  in  1  hold PC and RAS this cycle.
- flush  in  1  redirect to flush_pc; overrides stall and sel.
- flush_pc  in  XLEN  redirect target.
- sel  in  3  next-PC mode; encodings in package: SEQ=0, JMP=1, BR=2, JR=3, CALL=4, RET=5; 6 and 7 are reserved.
- imm_j  in  IMM_J_W  absolute-jump immediate.
- imm_b  in  IMM_B_W  branch byte offset.
- ext_op  in  1  1 = sign-extend imm_b, 0 = zero-extend.
- reg_target  in  XLEN  register operand for JR, and RET fallback.
- pc  out  XLEN  current PC (registered).
- pc_plus4  out  XLEN  pc+4 (combinational).
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_ovf  out  1  sticky: a push overwrote an entry.
- ras_unf  out  1  sticky: a RET occurred with the RAS empty.

Behaviour:
- Reset (async assert, any time, including mid-operation):
  - pc=RESET_PC; RAS pointer=0, count=0, all entries 0.
  - ras_ovf=0, ras_unf=0; ras_empty=1, ras_full=0.
- Next-PC targets (all sums modulo 2^XLEN, wrap silently):
  - SEQ: pc+4.
  - JMP: {pc[XLEN-1:IMM_J_W], imm_j}.
  - BR: pc+4+ext(imm_b); the offset is in bytes, not shifted.
  - JR: reg_target.
  - CALL: same target as JMP; push pc+4.
  - RET: RAS top if count>0, else reg_target with ras_unf set; pop if count>0.
  - Reserved sel: treated as SEQ, no RAS effect.
- Update rules, evaluated on each rising clk in priority order:
  - flush: pc<=flush_pc; RAS unchanged; stall and sel ignored.
  - else stall: pc, RAS and flags hold.
  - else: pc<=target. Latency is 1 cycle: the target is visible on pc the cycle after sel is sampled.
- RAS organisation: circular buffer. Pointer tp indexes the next free slot; top = entry[tp-1].
- Push:
  - entry[tp]<=value; tp++ (wraps at RAS_DEPTH).
  - count saturates at RAS_DEPTH.
  - A push while full overwrites the oldest entry and sets ras_ovf.
- Pop: tp-- (wraps); count--. A pop while empty is prevented by the RET fallback.
- Sticky flags clear only on reset.
- ras_empty and ras_full are derived from registered count, so they change with state, not combinationally from sel.
- Nothing else is stateful; pc_plus4 is purely combinational from pc.

Optional Feature:
- Macro: PC_SEQ_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign (1 bit) and parameter TRAP_VEC (default 32'h0000_0080).
  - An unstalled, unflushed update whose target[1:0]!=0 loads pc<=TRAP_VEC instead of the target.
  - misalign is pulsed high for that one cycle.
  - The RAS effect of the offending CALL or RET still occurs.
- Undefined: the port and check are absent, and misaligned targets load unchanged.

Decomposition:
- Package pc_seq_pkg:
  - sel encodings as a typedef enum, pc_sel_t (3 bits).
  - Constant PC_INC=4.
  - Default TRAP_VEC.
- Natural sub-module: pc_ras, which holds the circular stack, count, full/empty and overflow logic, with push/pop/wdata/top ports.
- Target mux and PC register stay in pc_seq_unit.

Test Plan:
- Reset, then 3 cycles SEQ -> pc = 0, 4, 8, 12. Assert reset mid-run -> pc=0 immediately, without waiting for clk.
- pc=0x100; BR with imm_b=16'hFFF0, ext_op=1 -> pc=0xF4. Repeat with ext_op=0 -> pc=0x100F4.
- pc=0x4000_0010; CALL with imm_j=0x0000200 -> pc=0x4000_0200 and RAS top=0x4000_0014. Then RET -> pc=0x4000_0014, ras_empty=1.
- Nine CALLs with RAS_DEPTH=8 -> ras_full=1 and ras_ovf=1. Nine RETs -> the first 8 return the newest-first addresses; the 9th takes reg_target and sets ras_unf.
- Assert stall and flush together with flush_pc=0x200, sel=CALL -> pc=0x200 and RAS count unchanged. Stall alone with sel=JR -> pc held.
- With the macro defined: JR to 0x102 -> pc=TRAP_VEC and misalign pulses for 1 cycle. Without the macro -> pc=0x102.
